// File: rtl/systolic_skew_feeder.sv
// Edge feeder for an NxN systolic array: skews each accepted K-step diagonally across
// the west/north lanes, drains the skew after the last beat and waits for the array to commit.

module skew_lane #(
  parameter int DEPTH = 1,
  parameter int DW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          cm_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          en_o,
  output logic          cm_o,
  output logic [DW-1:0] a_o,
  output logic [DW-1:0] b_o
);

  logic [DW-1:0] a_q  [DEPTH];
  logic [DW-1:0] b_q  [DEPTH];
  logic          en_q [DEPTH];
  logic          cm_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < DEPTH; s++) begin
        a_q[s]  <= '0;
        b_q[s]  <= '0;
        en_q[s] <= 1'b0;
        cm_q[s] <= 1'b0;
      end
    end else begin
      a_q[0]  <= a_i;
      b_q[0]  <= b_i;
      en_q[0] <= en_i;
      cm_q[0] <= cm_i;
      for (int s = 1; s < DEPTH; s++) begin
        a_q[s]  <= a_q[s-1];
        b_q[s]  <= b_q[s-1];
        en_q[s] <= en_q[s-1];
        cm_q[s] <= cm_q[s-1];
      end
    end
  end

  assign a_o  = a_q[DEPTH-1];
  assign b_o  = b_q[DEPTH-1];
  assign en_o = en_q[DEPTH-1];
  assign cm_o = cm_q[DEPTH-1];

endmodule

module systolic_skew_feeder #(
  parameter int N  = 8,
  parameter int DW = 32,
  parameter int KW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [N*DW-1:0] in_a_i,
  input  logic [N*DW-1:0] in_b_i,
  input  logic            in_last_i,
  output logic [N*DW-1:0] aleft_o,
  output logic [N*DW-1:0] bup_o,
  output logic [N-1:0]    enleft_o,
  output logic [N-1:0]    enup_o,
  output logic [N-1:0]    cmleft_o,
  output logic [N-1:0]    cmup_o,
  input  logic            arr_done_i,
  output logic            busy_o,
  output logic [KW-1:0]   k_count_o,
  output logic            tile_done_o
);

  // state    | meaning
  // S_IDLE   | waiting for first beat of a tile
  // S_STREAM | accepting beats until in_last
  // S_FLUSH  | draining the skew, N-1 cycles
  // S_WAIT   | waiting for array commit (arr_done)
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_WAIT} state_e;

  localparam int FCW = (N > 2) ? $clog2(N - 1) : 1;
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(N - 2);

  state_e          state_q, state_d;
  logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
  logic [KW-1:0]   k_count_q, k_count_d;
  logic            accept;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
      k_count_q   <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      k_count_q   <= k_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    k_count_d   = k_count_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          k_count_d = KW'(1);
          if (in_last_i) begin
            state_d     = S_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (accept) begin
          k_count_d = k_count_q + KW'(1);
          if (in_last_i) begin
            state_d     = S_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == '0) state_d = S_WAIT;
        else                   flush_cnt_d = flush_cnt_q - FCW'(1);
      end
      S_WAIT: begin
        if (arr_done_i) begin
          state_d   = S_IDLE;
          k_count_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == S_IDLE) || (state_q == S_STREAM);
    busy_o      = (state_q != S_IDLE);
    // combinational so the next tile can start the cycle right after the pulse
    tile_done_o = (state_q == S_WAIT) && arr_done_i && !rst_i;
  end

  assign accept    = in_valid_i & in_ready_o;
  assign k_count_o = k_count_q;

  // lane i is a chain of i+1 flops; bubbles enter as zero data with en=0
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic cm_lane;

    skew_lane #(.DEPTH(i + 1), .DW(DW)) u_lane (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (accept),
      .cm_i  (accept & in_last_i),
      .a_i   (accept ? in_a_i[i*DW +: DW] : {DW{1'b0}}),
      .b_i   (accept ? in_b_i[i*DW +: DW] : {DW{1'b0}}),
      .en_o  (enleft_o[i]),
      .cm_o  (cm_lane),
      .a_o   (aleft_o[i*DW +: DW]),
      .b_o   (bup_o[i*DW +: DW])
    );

    assign enup_o[i]   = enleft_o[i];
    assign cmleft_o[i] = cm_lane;
    assign cmup_o[i]   = cm_lane;
  end

endmodule
